// File: rtl/seq_sll_if.sv
// Start/ready handshake bundle for the sequential left shifter.
// data_exception exists only when SLL_OVF_EN is defined.
interface seq_sll_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               ctrl_start;
    logic [WIDTH-1:0]   data_operandA;
    logic [SHAMT_W-1:0] data_shamt;
    logic [WIDTH-1:0]   data_result;
    logic               data_resultRDY;
    logic               busy;
`ifdef SLL_OVF_EN
    logic               data_exception;

    modport master (
        output ctrl_start, data_operandA, data_shamt,
        input  data_result, data_resultRDY, busy, data_exception
    );
    modport slave (
        input  ctrl_start, data_operandA, data_shamt,
        output data_result, data_resultRDY, busy, data_exception
    );
`else
    modport master (
        output ctrl_start, data_operandA, data_shamt,
        input  data_result, data_resultRDY, busy
    );
    modport slave (
        input  ctrl_start, data_operandA, data_shamt,
        output data_result, data_resultRDY, busy
    );
`endif
endinterface

// File: rtl/seq_sll_unit.sv
// Multi-cycle logical left shifter, up to STEP positions per clock.
// Optional signed-overflow flag on data_exception when SLL_OVF_EN is defined.
module seq_sll_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic       clock,
    input  logic       reset,
    seq_sll_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W+1)'(STEP);

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_work, r_result, w_work_nxt;
    logic [SHAMT_W-1:0] r_rem, w_rem_nxt, w_s;
    logic               w_accept;

    // Per-cycle shift distance is min(STEP, rem), so rem never underflows
    assign w_s        = ({1'b0, r_rem} < STEP_L) ? r_rem : STEP_L[SHAMT_W-1:0];
    assign w_work_nxt = r_work << w_s;
    assign w_rem_nxt  = r_rem - w_s;
    assign w_accept   = (r_state == IDLE) && bus.ctrl_start;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.ctrl_start)
                         w_state_nxt = (bus.data_shamt == '0) ? DONE : SHIFT;
            SHIFT:   if (w_rem_nxt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_result is loaded only on the edge entering DONE so it stays stable afterwards
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_work   <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_work <= bus.data_operandA;
            r_rem  <= bus.data_shamt;
            if (bus.data_shamt == '0) r_result <= bus.data_operandA;
        end else if (r_state == SHIFT) begin
            r_work <= w_work_nxt;
            r_rem  <= w_rem_nxt;
            if (w_rem_nxt == '0) r_result <= w_work_nxt;
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_resultRDY = (r_state == DONE);
    assign bus.busy           = (r_state != IDLE);

`ifdef SLL_OVF_EN
    logic             r_sign, r_flag, w_ovf;
    logic [WIDTH-1:0] w_mask;

    // Overflow: any bit leaving the top, or the new sign bit, disagrees with A's sign
    assign w_mask = ~({WIDTH{1'b1}} >> w_s);
    assign w_ovf  = (|((r_work ^ {WIDTH{r_sign}}) & w_mask)) |
                    (w_work_nxt[WIDTH-1] ^ r_sign);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sign <= 1'b0;
            r_flag <= 1'b0;
        end else if (w_accept) begin
            r_sign <= bus.data_operandA[WIDTH-1];
            r_flag <= 1'b0;
        end else if ((r_state == SHIFT) && w_ovf) begin
            r_flag <= 1'b1;
        end
    end

    assign bus.data_exception = (r_state == DONE) && r_flag;
`endif
endmodule
